// File: rtl/elbeth_defs_pkg.sv
// Shared ELBETH definitions: fetch FSM encoding and architectural constants.
package elbeth_defs;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_DRAIN = 2'b11
  } fetch_state_e;

  localparam logic [0:31] ELBETH_NOP_INSTR    = 32'h0100_0000;
  localparam logic [0:31] ELBETH_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/elbeth_add4.sv
// Sequential-address incrementer: sum_o = a_i + 4, wrapping modulo 2^32.
module elbeth_add4 (
  input  logic [0:31] a_i,
  output logic [0:31] sum_o
);

  assign sum_o = a_i + 32'd4;

endmodule

// File: rtl/elbeth_fetch_stage.sv
// ELBETH instruction fetch: owns the PC, issues one outstanding imem request,
// and holds the returned word in the IF/ID register until decode accepts it.
module elbeth_fetch_stage
  import elbeth_defs::*;
#(
  parameter logic [0:31] RESET_VECTOR = ELBETH_RESET_VECTOR,
  parameter logic [0:31] NOP_INSTR    = ELBETH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [0:31] if_instr,
  output logic [0:31] if_pc,
  output logic [0:31] if_npc
);

  fetch_state_e state_q;
  logic         imem_req_q;
  logic         valid_q;
  logic [0:31]  pc_q;
  logic [0:31]  req_addr_q;
  logic [0:31]  instr_q;
  logic [0:31]  ipc_q;
  logic [0:31]  inpc_q;
  logic [0:31]  seq_addr;
  logic [0:31]  target;

  assign target = {redirect_pc[0:29], 2'b00};

  elbeth_add4 u_add4 (
    .a_i   (req_addr_q),
    .sum_o (seq_addr)
  );

  // NOTE: every register here is written with <= so all updates see the
  // pre-edge values; the redirect writes below are then safely refined per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ISSUE;
      imem_req_q <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      instr_q    <= NOP_INSTR;
      ipc_q      <= '0;
      inpc_q     <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q    <= target;
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end

      case (state_q)
        ST_ISSUE: begin
          if (!redirect_valid) begin
            req_addr_q <= pc_q;
            imem_req_q <= 1'b1;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            if (redirect_valid) begin
              state_q <= ST_ISSUE;
            end else begin
              instr_q <= imem_rdata;
              ipc_q   <= req_addr_q;
              inpc_q  <= seq_addr;
              pc_q    <= seq_addr;
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            // The bus cannot cancel an in-flight request; let it land and drop it.
            state_q <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            state_q <= ST_ISSUE;
          end else if (id_ready) begin
            valid_q    <= 1'b0;
            req_addr_q <= pc_q;
            imem_req_q <= 1'b1;
            state_q    <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= ST_ISSUE;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= ST_ISSUE;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = req_addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
  assign if_npc    = inpc_q;

endmodule
